// File: rtl/psg_pkg.sv
// Shared definitions for the PSG output mixer.
//   mix_state_e : mix FSM states (idle, accumulate, output)
//   VOL_W       : width of a per-channel volume code
//   VOL_SHIFT   : right shift applied after the volume multiply (vol=15 -> x15/16)
//   acc_width() : accumulator width that can hold NCH full-scale terms without wrapping
package psg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StOut
  } mix_state_e;

  localparam int unsigned VOL_W     = 4;
  localparam int unsigned VOL_SHIFT = 4;

  // Each term is at most IW+1 bits; NCH of them need clog2(NCH) extra bits.
  function automatic int unsigned acc_width(input int unsigned iw, input int unsigned nch);
    return iw + 1 + $clog2(nch);
  endfunction

endpackage

// File: rtl/psg_output_mixer_if.sv
// Bus bundle between the voice filter stage, the output mixer and the DAC side.
//   cnt      : clock-divider count, a mix pass starts when it is zero
//   ufi/fi   : packed unfiltered/filtered channel samples, channel k at [k*IW +: IW]
//   vol      : packed 4-bit volumes, channel k at [k*4 +: 4]
//   ch_en    : per-channel enable
//   o        : mixed, saturated output; o_valid pulses when it updates
//   busy     : a mix pass is in progress
//   ovf      : sticky saturation / dropped-strobe flag
//   peak, peak_clr : only when PSG_MIX_PEAK_EN is defined
// Modports: master drives the inputs and consumes the results, slave is the mixer.
interface psg_output_mixer_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned IW    = 22,
  parameter int unsigned OW    = 22,
  parameter int unsigned DIV_W = 8
);

  logic [DIV_W-1:0]  cnt;
  logic [NCH*IW-1:0] ufi;
  logic [NCH*IW-1:0] fi;
  logic [NCH*4-1:0]  vol;
  logic [NCH-1:0]    ch_en;
  logic [OW-1:0]     o;
  logic              o_valid;
  logic              busy;
  logic              ovf;
`ifdef PSG_MIX_PEAK_EN
  logic              peak_clr;
  logic [OW-1:0]     peak;
`endif

`ifdef PSG_MIX_PEAK_EN
  modport master (
    output cnt, ufi, fi, vol, ch_en, peak_clr,
    input  o, o_valid, busy, ovf, peak
  );
  modport slave (
    input  cnt, ufi, fi, vol, ch_en, peak_clr,
    output o, o_valid, busy, ovf, peak
  );
`else
  modport master (
    output cnt, ufi, fi, vol, ch_en,
    input  o, o_valid, busy, ovf
  );
  modport slave (
    input  cnt, ufi, fi, vol, ch_en,
    output o, o_valid, busy, ovf
  );
`endif

endinterface

// File: rtl/psg_output_mixer_term.sv
// Single-channel mix term: ((ufi + fi) * vol) >> VOL_SHIFT, forced to zero when disabled.
//   ufi_i, fi_i : unsigned IW-bit channel samples
//   vol_i       : 4-bit volume
//   en_i        : channel enable
//   term_o      : IW+1-bit scaled term
module psg_mix_term
  import psg_pkg::*;
#(
  parameter int unsigned IW = 22
) (
  input  logic [IW-1:0]    ufi_i,
  input  logic [IW-1:0]    fi_i,
  input  logic [VOL_W-1:0] vol_i,
  input  logic             en_i,
  output logic [IW:0]      term_o
);

  localparam int unsigned PW = IW + 1 + VOL_W;

  logic [IW:0]   sum;
  logic [PW-1:0] prod;

  always_comb begin
    sum    = {1'b0, ufi_i} + {1'b0, fi_i};
    prod   = PW'(sum) * PW'(vol_i);
    term_o = en_i ? (IW + 1)'(prod >> VOL_SHIFT) : '0;
  end

endmodule

// File: rtl/psg_output_mixer.sv
// PSG output mixer: on a divider strobe (cnt == 0) in idle, snapshots all channel inputs and
// accumulates one channel term per cycle, then saturates the sum to OW bits.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : cnt, ufi, fi, vol, ch_en in; o, o_valid, busy, ovf out
// Optional: define PSG_MIX_PEAK_EN to add the peak-hold output (peak) and its clear (peak_clr).
module psg_output_mixer
  import psg_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned IW    = 22,
  parameter int unsigned OW    = 22,
  parameter int unsigned DIV_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  psg_output_mixer_if.slave   bus
);

  localparam int unsigned AW    = acc_width(IW, NCH);
  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW    = (AW > OW) ? AW : OW;
  localparam logic [CW-1:0] OMAX = CW'({OW{1'b1}});

  mix_state_e state_q, state_d;
  logic [IDX_W-1:0] ch_idx_q, ch_idx_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [OW-1:0]    o_q, o_d;
  logic             ovf_q, ovf_d;

  logic [IW-1:0]    ufi_q [NCH];
  logic [IW-1:0]    fi_q  [NCH];
  logic [VOL_W-1:0] vol_q [NCH];
  logic [NCH-1:0]   en_q;

  logic          strobe;
  logic          snap;
  logic [IW:0]   term;
  logic [AW-1:0] acc_sum;
  logic [CW-1:0] sum_ext;
  logic          sat_hit;
  logic [OW-1:0] o_sat;

  assign strobe = (bus.cnt == DIV_W'(0));
  assign snap   = (state_q == StIdle) && strobe;

  // Snapshot: the pass only ever reads these, so input changes mid-pass are invisible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NCH; k++) begin
        ufi_q[k] <= '0;
        fi_q[k]  <= '0;
        vol_q[k] <= '0;
      end
      en_q <= '0;
    end else if (snap) begin
      for (int k = 0; k < NCH; k++) begin
        ufi_q[k] <= bus.ufi[k*IW +: IW];
        fi_q[k]  <= bus.fi[k*IW +: IW];
        vol_q[k] <= bus.vol[k*VOL_W +: VOL_W];
      end
      en_q <= bus.ch_en;
    end
  end

  psg_mix_term #(
    .IW (IW)
  ) u_term (
    .ufi_i  (ufi_q[ch_idx_q]),
    .fi_i   (fi_q[ch_idx_q]),
    .vol_i  (vol_q[ch_idx_q]),
    .en_i   (en_q[ch_idx_q]),
    .term_o (term)
  );

  // Saturate the running sum including the current term, so o is ready on entry to StOut.
  always_comb begin
    acc_sum = acc_q + AW'(term);
    sum_ext = CW'(acc_sum);
    sat_hit = (sum_ext > OMAX);
    o_sat   = sat_hit ? OW'(OMAX) : OW'(sum_ext);
  end

  always_comb begin
    state_d  = state_q;
    ch_idx_d = ch_idx_q;
    acc_d    = acc_q;
    o_d      = o_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (strobe) begin
          state_d  = StAcc;
          ch_idx_d = '0;
          acc_d    = '0;
        end
      end
      StAcc: begin
        if (strobe) ovf_d = 1'b1;  // dropped strobe
        acc_d = acc_sum;
        if (ch_idx_q == IDX_W'(NCH - 1)) begin
          state_d = StOut;
          o_d     = o_sat;
          if (sat_hit) ovf_d = 1'b1;
        end else begin
          ch_idx_d = ch_idx_q + IDX_W'(1);
        end
      end
      StOut: begin
        if (strobe) ovf_d = 1'b1;  // dropped strobe
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      ch_idx_q <= '0;
      acc_q    <= '0;
      o_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_idx_q <= ch_idx_d;
      acc_q    <= acc_d;
      o_q      <= o_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.o       = o_q;
  assign bus.o_valid = (state_q == StOut);
  assign bus.busy    = (state_q != StIdle);
  assign bus.ovf     = ovf_q;

`ifdef PSG_MIX_PEAK_EN
  logic [OW-1:0] peak_q;

  // Clear wins over an update landing in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      peak_q <= '0;
    end else if (bus.peak_clr) begin
      peak_q <= '0;
    end else if (bus.o_valid && (o_q > peak_q)) begin
      peak_q <= o_q;
    end
  end

  assign bus.peak = peak_q;
`endif

endmodule

// File: tb/tb_psg_output_mixer.sv
module tb_psg_output_mixer;

  localparam int unsigned NCH = 4;
  localparam int unsigned IW  = 22;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  bit   ovf_exp_a;
  bit   ovf_exp_b;
`ifdef PSG_MIX_PEAK_EN
  longint peak_exp;
`endif

  psg_output_mixer_if #(.NCH(NCH), .IW(IW), .OW(22), .DIV_W(8)) if_a ();
  psg_output_mixer_if #(.NCH(NCH), .IW(IW), .OW(26), .DIV_W(8)) if_b ();

  assign if_b.cnt   = if_a.cnt;
  assign if_b.ufi   = if_a.ufi;
  assign if_b.fi    = if_a.fi;
  assign if_b.vol   = if_a.vol;
  assign if_b.ch_en = if_a.ch_en;
`ifdef PSG_MIX_PEAK_EN
  assign if_b.peak_clr = if_a.peak_clr;
`endif

  psg_output_mixer #(.NCH(NCH), .IW(IW), .OW(22), .DIV_W(8)) u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if_a)
  );

  psg_output_mixer #(.NCH(NCH), .IW(IW), .OW(26), .DIV_W(8)) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sum over enabled channels of floor((u+f)*v/16), then clamp to 2^ow-1.
  function automatic void model(input logic [NCH*IW-1:0] u, input logic [NCH*IW-1:0] f,
                                input logic [NCH*4-1:0] v, input logic [NCH-1:0] e,
                                input int ow, output longint res, output bit clamp);
    longint s;
    longint mx;
    s = 0;
    for (int k = 0; k < NCH; k++) begin
      if (e[k]) s += ((longint'(u[k*IW +: IW]) + longint'(f[k*IW +: IW])) *
                      longint'(v[k*4 +: 4])) / 16;
    end
    mx    = (longint'(1) << ow) - 1;
    clamp = (s > mx);
    res   = clamp ? mx : s;
  endfunction

  // One full pass from a strobe; checks latency, both outputs, ovf and return to idle.
  task automatic do_pass(input logic [NCH*IW-1:0] u, input logic [NCH*IW-1:0] f,
                         input logic [NCH*4-1:0] v, input logic [NCH-1:0] e,
                         input bit clr_at_valid, input string tag);
    longint exp_a, exp_b;
    bit     cl_a, cl_b;
    int     cycles;
    model(u, f, v, e, 22, exp_a, cl_a);
    model(u, f, v, e, 26, exp_b, cl_b);
    if_a.ufi   = u;
    if_a.fi    = f;
    if_a.vol   = v;
    if_a.ch_en = e;
    if_a.cnt   = 8'd0;
    tick();
    if_a.cnt = 8'd7;
    chk({tag, "_busy"}, 64'(if_a.busy), 64'd1);
    cycles = 1;
    while (!if_a.o_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    if (cl_a) ovf_exp_a = 1'b1;
    if (cl_b) ovf_exp_b = 1'b1;
    chk({tag, "_lat"}, 64'(cycles), 64'(NCH + 1));
    chk({tag, "_o_a"}, 64'(if_a.o), 64'(exp_a));
    chk({tag, "_o_b"}, 64'(if_b.o), 64'(exp_b));
    chk({tag, "_ovf_a"}, 64'(if_a.ovf), 64'(ovf_exp_a));
    chk({tag, "_ovf_b"}, 64'(if_b.ovf), 64'(ovf_exp_b));
`ifdef PSG_MIX_PEAK_EN
    if (clr_at_valid) begin
      if_a.peak_clr = 1'b1;
      peak_exp = 0;
    end else if (exp_a > peak_exp) begin
      peak_exp = exp_a;
    end
`endif
    tick();
`ifdef PSG_MIX_PEAK_EN
    if_a.peak_clr = 1'b0;
    chk({tag, "_peak"}, 64'(if_a.peak), 64'(peak_exp));
`else
    if (clr_at_valid) $display("note: peak clear requested without peak feature");
`endif
    chk({tag, "_idle"}, {62'd0, if_a.busy, if_a.o_valid}, 64'd0);
  endtask

  initial begin
    logic [NCH*IW-1:0] u, f;
    logic [NCH*4-1:0]  v;
    logic [NCH-1:0]    e;
    longint            exp_o;
    bit                cl;
    int                nvalid;
    logic [21:0]       o_seen;

    n_assert  = 0;
    n_fail    = 0;
    ovf_exp_a = 1'b0;
    ovf_exp_b = 1'b0;
`ifdef PSG_MIX_PEAK_EN
    peak_exp      = 0;
    if_a.peak_clr = 1'b0;
`endif
    rst_n      = 1'b0;
    if_a.cnt   = 8'd7;
    if_a.ufi   = '0;
    if_a.fi    = '0;
    if_a.vol   = '0;
    if_a.ch_en = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_o", 64'(if_a.o), 64'd0);
    chk("rst_flags", {60'd0, if_a.o_valid, if_a.busy, if_a.ovf, 1'b0}, 64'd0);

    // Single channel: (1000+600)*15/16 = 1500.
    u = '0; f = '0; v = '0; e = '0;
    u[21:0] = 22'd1000; f[21:0] = 22'd600; v[3:0] = 4'd15; e = 4'b0001;
    u[IW +: IW] = 22'd999; v[4 +: 4] = 4'd9;  // disabled channel must not contribute
    do_pass(u, f, v, e, 1'b0, "ch0");
    chk("ch0_exact", 64'(if_a.o), 64'd1500);

    // Full scale on all channels: clamps at OW=22, fits at OW=26.
    u = {NCH{22'h3FFFFF}}; f = u; v = {NCH{4'd15}}; e = '1;
    do_pass(u, f, v, e, 1'b0, "full");
    chk("full_a", 64'(if_a.o), 64'h3FFFFF);

    // Randomised passes, back-to-back after the previous pass.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NCH; k++) begin
        u[k*IW +: IW] = (r < 3) ? 22'($urandom_range(0, 65535)) : 22'($urandom);
        f[k*IW +: IW] = (r < 3) ? 22'($urandom_range(0, 65535)) : 22'($urandom);
        v[k*4 +: 4]   = 4'($urandom);
      end
      e = 4'($urandom);
      do_pass(u, f, v, e, 1'b0, "rnd");
    end

    // Snapshot isolation and dropped strobe.
    u = '0; f = '0; v = '0; e = 4'b0001;
    u[21:0] = 22'd2000; f[21:0] = 22'd48; v[3:0] = 4'd8;
    model(u, f, v, e, 22, exp_o, cl);
    if_a.ufi = u; if_a.fi = f; if_a.vol = v; if_a.ch_en = e;
    if_a.cnt = 8'd0;
    tick();
    if_a.cnt = 8'd3;
    if_a.ufi = {NCH{22'h2AAAAA}};
    tick();
    if_a.cnt = 8'd0;
    tick();
    if_a.cnt = 8'd3;
    nvalid = 0;
    o_seen = '0;
    for (int c = 0; c < 12; c++) begin
      if (if_a.o_valid) begin
        nvalid++;
        o_seen = if_a.o;
      end
      tick();
    end
    ovf_exp_a = 1'b1;
    ovf_exp_b = 1'b1;
    chk("drop_nvalid", 64'(nvalid), 64'd1);
    chk("drop_o", 64'(o_seen), 64'(exp_o));
    chk("drop_ovf_a", 64'(if_a.ovf), 64'd1);
    chk("drop_ovf_b", 64'(if_b.ovf), 64'd1);
    chk("drop_idle", 64'(if_a.busy), 64'd0);

    // Reset in the middle of accumulation.
    u = {NCH{22'd12345}}; f = u; v = {NCH{4'd11}}; e = '1;
    if_a.ufi = u; if_a.fi = f; if_a.vol = v; if_a.ch_en = e;
    if_a.cnt = 8'd0;
    tick();
    if_a.cnt = 8'd3;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o", 64'(if_a.o), 64'd0);
    chk("mid_rst_flags", {61'd0, if_a.o_valid, if_a.busy, if_a.ovf}, 64'd0);
    nvalid = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (if_a.o_valid) nvalid++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (if_a.o_valid) nvalid++;
    end
    ovf_exp_a = 1'b0;
    ovf_exp_b = 1'b0;
    chk("mid_rst_novalid", 64'(nvalid), 64'd0);
    chk("mid_rst_ovf", 64'(if_b.ovf), 64'd0);

`ifdef PSG_MIX_PEAK_EN
    peak_exp = 0;
    u = '0; f = '0; v = '0; e = 4'b0001; v[3:0] = 4'd15;
    u[21:0] = 22'd534;  do_pass(u, f, v, e, 1'b0, "pk500");
    u[21:0] = 22'd1280; do_pass(u, f, v, e, 1'b0, "pk1200");
    u[21:0] = 22'd320;  do_pass(u, f, v, e, 1'b0, "pk300");
    chk("peak_max", 64'(if_a.peak), 64'd1200);
    u[21:0] = 22'd854;  do_pass(u, f, v, e, 1'b1, "pkclr800");
    chk("peak_clr", 64'(if_a.peak), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
